// File: rtl/multi_cycle_control.sv
// multi_cycle_control
// Control FSM for a multi-cycle CPU. Each instruction is stepped through the
// IF/ID/EXE/MEM/WB phases (or a subset of them); HALT is a terminal state left
// only through reset. All datapath controls are decoded combinationally from
// the current state, the instruction opcode and the ALU zero flag.
//
// Ports:
//   CLK        in   system clock, rising-edge active
//   Reset      in   asynchronous active-low reset, forces IF
//   opcode     in   [5:0] instruction opcode (stable from end of IF)
//   zero       in   ALU zero flag, consulted in EXE for beq/bne
//   state      out  [2:0] IF=000 ID=001 EXE=010 MEM=011 WB=100 HALT=111
//   PCWre      out  PC write enable (last state of each instruction)
//   PCSrc      out  [1:0] 00 PC+4, 01 branch, 10 rs (jr), 11 jump target
//   IRWre      out  instruction-register load
//   RegWre     out  register-file write
//   RegDst     out  [1:0] 00 $31, 01 rt, 10 rd
//   WrRegDSrc  out  register write data: 0 PC+4, 1 DB bus
//   DBDataSrc  out  DB bus source: 0 ALU, 1 memory
//   ALUSrcB    out  ALU B operand: 0 rt, 1 extended immediate
//   ExtSel     out  immediate extension: 0 zero, 1 sign
//   ALUOp      out  [2:0] 000 add, 001 sub, 100 or
//   mRD, mWR   out  data-memory read / write strobes

module multi_cycle_control (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR
);

    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EXE  = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_HALT = 3'b111;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [2:0] state_q;
    logic [2:0] state_d;

    logic is_rtype_s;
    logic is_imm_s;
    logic is_lw_s;
    logic is_sw_s;
    logic is_beq_s;
    logic is_bne_s;
    logic is_branch_s;
    logic is_j_s;
    logic is_jal_s;
    logic is_jr_s;
    logic is_halt_s;
    logic is_undef_s;
    logic is_alu_s;

    // Opcode class decode.
    always_comb begin
        is_rtype_s  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR);
        is_imm_s    = (opcode == OP_ADDI) || (opcode == OP_ORI);
        is_lw_s     = (opcode == OP_LW);
        is_sw_s     = (opcode == OP_SW);
        is_beq_s    = (opcode == OP_BEQ);
        is_bne_s    = (opcode == OP_BNE);
        is_branch_s = is_beq_s || is_bne_s;
        is_j_s      = (opcode == OP_J);
        is_jal_s    = (opcode == OP_JAL);
        is_jr_s     = (opcode == OP_JR);
        is_halt_s   = (opcode == OP_HALT);
        is_alu_s    = is_rtype_s || is_imm_s;
        is_undef_s  = !(is_alu_s || is_lw_s || is_sw_s || is_branch_s ||
                        is_j_s || is_jal_s || is_jr_s || is_halt_s);
    end

    // Next-state selection; unreachable encodings recover to IF.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: begin
                state_d = S_ID;
            end
            S_ID: begin
                if (is_halt_s) begin
                    state_d = S_HALT;
                end else if (is_alu_s || is_lw_s || is_sw_s || is_branch_s) begin
                    state_d = S_EXE;
                end else begin
                    state_d = S_IF;   // jumps and undefined opcodes finish in ID
                end
            end
            S_EXE: begin
                if (is_lw_s || is_sw_s) begin
                    state_d = S_MEM;
                end else if (is_alu_s) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                if (is_lw_s) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                state_d = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // State register; reset takes effect immediately.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Control decode from state, opcode and zero.
    always_comb begin
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = 3'b000;
        mRD       = 1'b0;
        mWR       = 1'b0;

        // ALU controls are held constant across EXE, MEM and WB so the
        // ALU result stays valid while memory and write-back use it.
        if ((state_q == S_EXE) || (state_q == S_MEM) || (state_q == S_WB)) begin
            ALUSrcB = is_imm_s || is_lw_s || is_sw_s;
            ExtSel  = (opcode != OP_ORI);
            if ((opcode == OP_OR) || (opcode == OP_ORI)) begin
                ALUOp = 3'b100;
            end else if ((opcode == OP_SUB) || is_branch_s) begin
                ALUOp = 3'b001;
            end else begin
                ALUOp = 3'b000;
            end
        end else begin
            ALUSrcB = 1'b0;
        end

        case (state_q)
            S_IF: begin
                IRWre = 1'b1;
            end
            S_ID: begin
                if (is_j_s || is_jal_s) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b11;
                end else if (is_jr_s) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b10;
                end else if (is_undef_s) begin
                    PCWre = 1'b1;
                    PCSrc = 2'b00;
                end else begin
                    PCWre = 1'b0;
                end
                if (is_jal_s) begin
                    RegWre    = 1'b1;   // link: $31 <= PC+4
                    RegDst    = 2'b00;
                    WrRegDSrc = 1'b0;
                end else begin
                    RegWre = 1'b0;
                end
            end
            S_EXE: begin
                if (is_branch_s) begin
                    PCWre = 1'b1;
                    if ((is_beq_s && zero) || (is_bne_s && !zero)) begin
                        PCSrc = 2'b01;
                    end else begin
                        PCSrc = 2'b00;
                    end
                end else begin
                    PCWre = 1'b0;
                end
            end
            S_MEM: begin
                if (is_lw_s) begin
                    mRD = 1'b1;
                end else if (is_sw_s) begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                    PCSrc = 2'b00;
                end else begin
                    mRD = 1'b0;
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = 2'b00;
                DBDataSrc = is_lw_s;
                if (is_rtype_s) begin
                    RegDst = 2'b10;
                end else begin
                    RegDst = 2'b01;
                end
            end
            default: begin
                // HALT and unused encodings drive nothing.
                PCWre = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

    logic       CLK;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;

    int n_cmp;
    int n_bad;

    typedef logic [18:0] vec_t;
    typedef logic [2:0]  st_q_t[$];

    multi_cycle_control dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .state(state), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .DBDataSrc(DBDataSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    vec_t obs;
    assign obs = {state, PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc,
                  DBDataSrc, ALUSrcB, ExtSel, ALUOp, mRD, mWR};

    // Reference: the list of states an instruction visits.
    function automatic st_q_t seq_of(input logic [5:0] op);
        st_q_t q;
        q = {3'd0, 3'd1};
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b000010, 6'b010010: begin
                q.push_back(3'd2); q.push_back(3'd4);
            end
            6'b110001: begin
                q.push_back(3'd2); q.push_back(3'd3); q.push_back(3'd4);
            end
            6'b110000: begin
                q.push_back(3'd2); q.push_back(3'd3);
            end
            6'b110100, 6'b110101: q.push_back(3'd2);
            6'b111111: q.push_back(3'd7);
            default: ;
        endcase
        return q;
    endfunction

    // Reference: expected output vector at step k of instruction op.
    function automatic vec_t ref_out(input logic [5:0] op, input logic z, input int k);
        st_q_t q;
        logic [2:0] s;
        logic pcwre, irwre, regwre, wrreg, dbd, alub, ext, mrd, mwr, last;
        logic [1:0] pcsrc, regdst;
        logic [2:0] aluop;
        q = seq_of(op);
        s = q[k];
        last = (k == q.size() - 1) && (op != 6'b111111);
        pcwre = last; pcsrc = 2'b00;
        if (last) begin
            if (op == 6'b111000 || op == 6'b111010) pcsrc = 2'b11;
            else if (op == 6'b111001) pcsrc = 2'b10;
            else if ((op == 6'b110100 && z) || (op == 6'b110101 && !z)) pcsrc = 2'b01;
        end
        irwre = (s == 3'd0);
        alub = 1'b0; ext = 1'b0; aluop = 3'b000;
        if (s == 3'd2 || s == 3'd3 || s == 3'd4) begin
            alub = (op == 6'b000010 || op == 6'b010010 || op == 6'b110001 || op == 6'b110000);
            ext  = (op != 6'b010010);
            if (op == 6'b010000 || op == 6'b010010) aluop = 3'b100;
            else if (op == 6'b000001 || op == 6'b110100 || op == 6'b110101) aluop = 3'b001;
        end
        regwre = (s == 3'd4) || (s == 3'd1 && op == 6'b111010);
        regdst = 2'b00;
        if (s == 3'd4) regdst = (op == 6'b000000 || op == 6'b000001 || op == 6'b010000) ? 2'b10 : 2'b01;
        wrreg = (s == 3'd4);
        dbd   = (s == 3'd4) && (op == 6'b110001);
        mrd   = (s == 3'd3) && (op == 6'b110001);
        mwr   = (s == 3'd3) && (op == 6'b110000);
        return {s, pcwre, pcsrc, irwre, regwre, regdst, wrreg, dbd, alub, ext, aluop, mrd, mwr};
    endfunction

    task automatic check(input string tag, input vec_t exp);
        #1;
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Run an instruction from step k0 to completion; called at a falling edge.
    task automatic run_from(input logic [5:0] op, input logic z, input int k0);
        st_q_t q;
        q = seq_of(op);
        for (int k = k0; k < q.size(); k++) begin
            zero = z;
            if (k == 0) opcode = 6'($urandom_range(0, 63));   // IF must ignore opcode
            else        opcode = op;
            check($sformatf("op%b_step%0d", op, k), ref_out(op, z, k));
            opcode = op;
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    logic [5:0] op_tbl [14];
    logic [5:0] rop;

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_tbl = '{6'b000000, 6'b000001, 6'b010000, 6'b000010, 6'b010010,
                   6'b110001, 6'b110000, 6'b110100, 6'b110101, 6'b111000,
                   6'b111010, 6'b111001, 6'b101010, 6'b011111};
        n_cmp = 0; n_bad = 0;
        Reset = 1'b0; opcode = 6'b000000; zero = 1'b0;
        #2;
        check("reset", ref_out(6'b000000, 1'b0, 0));
        @(negedge CLK);
        Reset = 1'b1;

        // Reset mid-EXE of add, then resume.
        run_from(6'b000000, 1'b0, 0);
        opcode = 6'b000000;
        check("add_if", ref_out(6'b000000, 1'b0, 0));
        @(posedge CLK); @(negedge CLK);
        check("add_id", ref_out(6'b000000, 1'b0, 1));
        @(posedge CLK); @(negedge CLK);
        check("add_exe", ref_out(6'b000000, 1'b0, 2));
        Reset = 1'b0;
        check("rst_mid_exe", ref_out(6'b000000, 1'b0, 0));
        @(negedge CLK);
        check("rst_hold", ref_out(6'b000000, 1'b0, 0));
        Reset = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("rst_release_id", ref_out(6'b000000, 1'b0, 1));
        @(posedge CLK); @(negedge CLK);
        run_from(6'b000000, 1'b0, 2);

        // Directed instructions.
        run_from(6'b110001, 1'b0, 0);   // lw
        run_from(6'b110000, 1'b1, 0);   // sw
        run_from(6'b110100, 1'b1, 0);   // beq taken
        run_from(6'b110100, 1'b0, 0);   // beq not taken
        run_from(6'b110101, 1'b1, 0);   // bne not taken
        run_from(6'b110101, 1'b0, 0);   // bne taken
        run_from(6'b111010, 1'b0, 0);   // jal
        run_from(6'b101010, 1'b0, 0);   // undefined
        run_from(6'b010010, 1'b0, 0);   // ori

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                rop = 6'($urandom_range(0, 63));
                if (rop == 6'b111111) rop = 6'b101010;
            end else begin
                rop = op_tbl[$urandom_range(0, 13)];
            end
            run_from(rop, 1'($urandom_range(0, 1)), 0);
        end

        // Halt: held with all outputs 0, then reset recovers.
        opcode = 6'b111111;
        check("halt_if", ref_out(6'b111111, 1'b0, 0));
        @(posedge CLK); @(negedge CLK);
        check("halt_id", ref_out(6'b111111, 1'b0, 1));
        @(posedge CLK); @(negedge CLK);
        for (int c = 0; c < 10; c++) begin
            zero = 1'($urandom_range(0, 1));
            check($sformatf("halt_hold%0d", c), ref_out(6'b111111, 1'b0, 2));
            @(posedge CLK); @(negedge CLK);
        end
        Reset = 1'b0;
        check("halt_reset", ref_out(6'b111111, 1'b0, 0));
        @(negedge CLK);
        Reset = 1'b1;
        opcode = 6'b000001;
        @(posedge CLK); @(negedge CLK);
        check("after_halt_id", ref_out(6'b000001, 1'b0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
